// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: operation enum, register/instruction types and the
// I-type opcode / REGIMM sub-code table used by both decoder and encoder.
package cpu_defs;

  typedef logic [4:0]  RegAddr_t;
  typedef logic [31:0] Inst_t;
  typedef logic [5:0]  Opcode_t;
  typedef logic [4:0]  RiSub_t;

  typedef enum logic [6:0] {
    OP_NOP,
    OP_ADD,  OP_ADDU, OP_SLT,  OP_SLTU, OP_AND,  OP_OR,   OP_XOR,  OP_LUI,
    OP_BEQ,  OP_BNE,  OP_BLEZ, OP_BGTZ,
    OP_LB,   OP_LH,   OP_LWL,  OP_LW,   OP_LBU,  OP_LHU,  OP_LWR,  OP_LL,
    OP_SB,   OP_SH,   OP_SWL,  OP_SW,   OP_SWR,  OP_SC,
    OP_TGE,  OP_TGEU, OP_TLT,  OP_TLTU, OP_TEQ,  OP_TNE,
    OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL,
    // R-type and J-type operations: not representable as an I-type word
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_SLL, OP_SRL, OP_SRA,
    OP_JR,   OP_JALR,  OP_J,   OP_JAL,  OP_SYSCALL, OP_BREAK
  } Oper_t;

  localparam Opcode_t OPC_SPECIAL = 6'b000000;
  localparam Opcode_t OPC_REGIMM  = 6'b000001;
  localparam Opcode_t OPC_BEQ     = 6'b000100;
  localparam Opcode_t OPC_BNE     = 6'b000101;
  localparam Opcode_t OPC_BLEZ    = 6'b000110;
  localparam Opcode_t OPC_BGTZ    = 6'b000111;
  localparam Opcode_t OPC_ADDI    = 6'b001000;
  localparam Opcode_t OPC_ADDIU   = 6'b001001;
  localparam Opcode_t OPC_SLTI    = 6'b001010;
  localparam Opcode_t OPC_SLTIU   = 6'b001011;
  localparam Opcode_t OPC_ANDI    = 6'b001100;
  localparam Opcode_t OPC_ORI     = 6'b001101;
  localparam Opcode_t OPC_XORI    = 6'b001110;
  localparam Opcode_t OPC_LUI     = 6'b001111;
  localparam Opcode_t OPC_LB      = 6'b100000;
  localparam Opcode_t OPC_LH      = 6'b100001;
  localparam Opcode_t OPC_LWL     = 6'b100010;
  localparam Opcode_t OPC_LW      = 6'b100011;
  localparam Opcode_t OPC_LBU     = 6'b100100;
  localparam Opcode_t OPC_LHU     = 6'b100101;
  localparam Opcode_t OPC_LWR     = 6'b100110;
  localparam Opcode_t OPC_SB      = 6'b101000;
  localparam Opcode_t OPC_SH      = 6'b101001;
  localparam Opcode_t OPC_SWL     = 6'b101010;
  localparam Opcode_t OPC_SW      = 6'b101011;
  localparam Opcode_t OPC_SWR     = 6'b101110;
  localparam Opcode_t OPC_LL      = 6'b110000;
  localparam Opcode_t OPC_SC      = 6'b111000;

  localparam RiSub_t RI_BLTZ   = 5'b00000;
  localparam RiSub_t RI_BGEZ   = 5'b00001;
  localparam RiSub_t RI_TGE    = 5'b01000;
  localparam RiSub_t RI_TGEU   = 5'b01001;
  localparam RiSub_t RI_TLT    = 5'b01010;
  localparam RiSub_t RI_TLTU   = 5'b01011;
  localparam RiSub_t RI_TEQ    = 5'b01100;
  localparam RiSub_t RI_TNE    = 5'b01110;
  localparam RiSub_t RI_BLTZAL = 5'b10000;
  localparam RiSub_t RI_BGEZAL = 5'b10001;

  function automatic Inst_t pack_itype(input Opcode_t opc, input RegAddr_t rs,
                                       input RegAddr_t rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/inst_enc_i_comb.sv
// Pure combinational I-type encoder: {op, rs, rt, imm} -> {inst, err}.
module inst_enc_i_comb
  import cpu_defs::*;
(
  input  Oper_t       op,
  input  RegAddr_t    rs,
  input  RegAddr_t    rt,
  input  logic [15:0] imm,
  output Inst_t       inst,
  output logic        err
);

  Opcode_t  opc;
  RegAddr_t rs_f;
  RegAddr_t rt_f;
  logic     known;
  logic     is_nop;

  always_comb begin
    opc    = OPC_SPECIAL;
    rs_f   = rs;
    rt_f   = rt;
    known  = 1'b1;
    is_nop = 1'b0;
    case (op)
      OP_NOP:    is_nop = 1'b1;
      OP_ADD:    opc = OPC_ADDI;
      OP_ADDU:   opc = OPC_ADDIU;
      OP_SLT:    opc = OPC_SLTI;
      OP_SLTU:   opc = OPC_SLTIU;
      OP_AND:    opc = OPC_ANDI;
      OP_OR:     opc = OPC_ORI;
      OP_XOR:    opc = OPC_XORI;
      OP_LUI: begin
        opc  = OPC_LUI;
        rs_f = '0;
      end
      OP_BEQ:    opc = OPC_BEQ;
      OP_BNE:    opc = OPC_BNE;
      OP_BLEZ: begin
        opc  = OPC_BLEZ;
        rt_f = '0;
      end
      OP_BGTZ: begin
        opc  = OPC_BGTZ;
        rt_f = '0;
      end
      OP_LB:     opc = OPC_LB;
      OP_LH:     opc = OPC_LH;
      OP_LWL:    opc = OPC_LWL;
      OP_LW:     opc = OPC_LW;
      OP_LBU:    opc = OPC_LBU;
      OP_LHU:    opc = OPC_LHU;
      OP_LWR:    opc = OPC_LWR;
      OP_LL:     opc = OPC_LL;
      OP_SB:     opc = OPC_SB;
      OP_SH:     opc = OPC_SH;
      OP_SWL:    opc = OPC_SWL;
      OP_SW:     opc = OPC_SW;
      OP_SWR:    opc = OPC_SWR;
      OP_SC:     opc = OPC_SC;
      // REGIMM: the rt slot carries the sub-code, the caller's rt is dropped
      OP_TGE:    begin opc = OPC_REGIMM; rt_f = RI_TGE;    end
      OP_TGEU:   begin opc = OPC_REGIMM; rt_f = RI_TGEU;   end
      OP_TLT:    begin opc = OPC_REGIMM; rt_f = RI_TLT;    end
      OP_TLTU:   begin opc = OPC_REGIMM; rt_f = RI_TLTU;   end
      OP_TEQ:    begin opc = OPC_REGIMM; rt_f = RI_TEQ;    end
      OP_TNE:    begin opc = OPC_REGIMM; rt_f = RI_TNE;    end
      OP_BLTZ:   begin opc = OPC_REGIMM; rt_f = RI_BLTZ;   end
      OP_BGEZ:   begin opc = OPC_REGIMM; rt_f = RI_BGEZ;   end
      OP_BLTZAL: begin opc = OPC_REGIMM; rt_f = RI_BLTZAL; end
      OP_BGEZAL: begin opc = OPC_REGIMM; rt_f = RI_BGEZAL; end
      default:   known = 1'b0;
    endcase

    err  = !known;
    inst = (known && !is_nop) ? pack_itype(opc, rs_f, rt_f, imm) : '0;
  end

endmodule

// File: rtl/inst_encoder_i.sv
// Streaming I-type instruction encoder with an output FIFO and a saturating
// counter of unencodable operations.
module inst_encoder_i
  import cpu_defs::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  Oper_t            in_op,
  input  RegAddr_t         in_rs,
  input  RegAddr_t         in_rt,
  input  logic [15:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output Inst_t            out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  Inst_t            enc_inst;
  logic             enc_err;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  Inst_t            inst_mem_q [FIFO_DEPTH];
  Inst_t            inst_mem_d [FIFO_DEPTH];
  logic             err_mem_q  [FIFO_DEPTH];
  logic             err_mem_d  [FIFO_DEPTH];
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  inst_enc_i_comb u_comb (
    .op   (in_op),
    .rs   (in_rs),
    .rt   (in_rt),
    .imm  (in_imm),
    .inst (enc_inst),
    .err  (enc_err)
  );

  assign full  = (occ_q == OCC_W'(FIFO_DEPTH));
  assign empty = (occ_q == '0);

  // Ready depends only on registered occupancy (and reset), never on out_ready
  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && out_ready;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    inst_mem_d = inst_mem_q;
    err_mem_d  = err_mem_q;
    err_cnt_d  = err_cnt_q;

    if (push) begin
      inst_mem_d[tail_q] = enc_inst;
      err_mem_d[tail_q]  = enc_err;
      tail_d             = tail_q + PTR_W'(1);
      if (enc_err && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end

    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      inst_mem_q <= '{default: '0};
      err_mem_q  <= '{default: 1'b0};
      err_cnt_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inst_mem_q <= inst_mem_d;
      err_mem_q  <= err_mem_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_valid = !empty;
  assign out_inst  = empty ? '0 : inst_mem_q[head_q];
  assign out_err   = empty ? 1'b0 : err_mem_q[head_q];
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder_i.sv
// Self-checking bench for inst_encoder_i: queue-based reference model plus
// directed vectors with hand-computed instruction words.
module tb_inst_encoder_i;
  import cpu_defs::*;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  Oper_t       in_op;
  RegAddr_t    in_rs;
  RegAddr_t    in_rt;
  logic [15:0] in_imm;
  logic        out_ready;

  logic        in_ready,  in_ready_s;
  logic        out_valid, out_valid_s;
  Inst_t       out_inst,  out_inst_s;
  logic        out_err,   out_err_s;
  logic [15:0] err_count;
  logic [1:0]  err_count_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  inst_encoder_i #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .err_count(err_count)
  );

  // Narrow counter instance: same stream, used to exercise saturation quickly
  inst_encoder_i #(.FIFO_DEPTH(DEPTH), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_inst(out_inst_s),
    .out_err(out_err_s), .err_count(err_count_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference encoding straight from the opcode table; bit 32 is the error flag
  function automatic logic [32:0] model_enc(input Oper_t op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [15:0] imm);
    int opc = -1;
    int sub = -1;
    bit zero_rs = 0;
    bit zero_rt = 0;
    case (op)
      OP_NOP:    return 33'd0;
      OP_ADD:    opc = 'o10;
      OP_ADDU:   opc = 'o11;
      OP_SLT:    opc = 'o12;
      OP_SLTU:   opc = 'o13;
      OP_AND:    opc = 'o14;
      OP_OR:     opc = 'o15;
      OP_XOR:    opc = 'o16;
      OP_LUI:    begin opc = 'o17; zero_rs = 1; end
      OP_BEQ:    opc = 4;
      OP_BNE:    opc = 5;
      OP_BLEZ:   begin opc = 6; zero_rt = 1; end
      OP_BGTZ:   begin opc = 7; zero_rt = 1; end
      OP_LB:     opc = 32;
      OP_LH:     opc = 33;
      OP_LWL:    opc = 34;
      OP_LW:     opc = 35;
      OP_LBU:    opc = 36;
      OP_LHU:    opc = 37;
      OP_LWR:    opc = 38;
      OP_LL:     opc = 48;
      OP_SB:     opc = 40;
      OP_SH:     opc = 41;
      OP_SWL:    opc = 42;
      OP_SW:     opc = 43;
      OP_SWR:    opc = 46;
      OP_SC:     opc = 56;
      OP_TGE:    sub = 8;
      OP_TGEU:   sub = 9;
      OP_TLT:    sub = 10;
      OP_TLTU:   sub = 11;
      OP_TEQ:    sub = 12;
      OP_TNE:    sub = 14;
      OP_BLTZ:   sub = 0;
      OP_BGEZ:   sub = 1;
      OP_BLTZAL: sub = 16;
      OP_BGEZAL: sub = 17;
      default:   return {1'b1, 32'd0};
    endcase
    if (sub >= 0) return {1'b0, 32'(1 * (1 << 26) + rs * (1 << 21) + sub * (1 << 16) + imm)};
    return {1'b0, 32'(opc * (1 << 26) + (zero_rs ? 0 : rs * (1 << 21))
                      + (zero_rt ? 0 : rt * (1 << 16)) + imm)};
  endfunction

  logic [32:0] exp_q[$];
  int unsigned err_total = 0;
  bit          live = 0;

  always @(posedge clk) begin
    bit do_pop, do_push;
    if (rst) begin
      exp_q.delete();
      err_total = 0;
      live = 1;
    end else if (live) begin
      do_pop  = (exp_q.size() != 0) && out_ready;
      do_push = in_valid && (exp_q.size() < DEPTH);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        logic [32:0] e;
        e = model_enc(in_op, in_rs, in_rt, in_imm);
        exp_q.push_back(e);
        if (e[32]) err_total++;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      logic [32:0] head;
      head = (exp_q.size() != 0) ? exp_q[0] : 33'd0;
      check("cmp_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("cmp_out_inst", out_inst, head[31:0]);
      check("cmp_out_err", 32'(out_err), 32'(head[32]));
      check("cmp_in_ready", 32'(in_ready), 32'(!rst && exp_q.size() < DEPTH));
      check("cmp_err_count", 32'(err_count), (err_total > 65535) ? 32'd65535 : err_total);
      check("cmp_err_count_sat2", 32'(err_count_s), (err_total > 3) ? 32'd3 : err_total);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input Oper_t op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [15:0] imm);
    in_valid = v;
    in_op    = op;
    in_rs    = rs;
    in_rt    = rt;
    in_imm   = imm;
  endtask

  initial begin
    Oper_t cur;
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, OP_OR, 5'd3, 5'd4, 16'h00FF);  // must not be accepted during reset

    step();
    @(negedge clk);
    check("in_ready_in_reset", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    drive(1'b0, OP_NOP, 5'd0, 5'd0, 16'h0);
    @(negedge clk);
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
    check("out_valid_after_reset", 32'(out_valid), 32'd0);

    // ORI
    out_ready = 1'b1;
    drive(1'b1, OP_OR, 5'd3, 5'd4, 16'h00FF);
    step();
    drive(1'b0, OP_NOP, 5'd0, 5'd0, 16'h0);
    @(negedge clk);
    check("ori_inst", out_inst, 32'h3464_00FF);
    check("ori_err", 32'(out_err), 32'd0);

    // LUI then BGEZAL back to back
    step();
    drive(1'b1, OP_LUI, 5'd7, 5'd1, 16'h8000);
    step();
    drive(1'b1, OP_BGEZAL, 5'd2, 5'd9, 16'hFFFF);
    @(negedge clk);
    check("lui_inst", out_inst, 32'h3C01_8000);
    step();
    drive(1'b0, OP_NOP, 5'd0, 5'd0, 16'h0);
    @(negedge clk);
    check("bgezal_inst", out_inst, 32'h0451_FFFF);

    // SW then BLEZ on consecutive cycles
    step();
    drive(1'b1, OP_SW, 5'd29, 5'd31, 16'h0004);
    step();
    drive(1'b1, OP_BLEZ, 5'd5, 5'd6, 16'h0010);
    @(negedge clk);
    check("sw_inst", out_inst, 32'hAFBF_0004);
    step();
    drive(1'b0, OP_NOP, 5'd0, 5'd0, 16'h0);
    @(negedge clk);
    check("blez_inst", out_inst, 32'h18A0_0010);
    step();

    // Unencodable op
    @(negedge clk);
    check("err_count_before", 32'(err_count), 32'd0);
    drive(1'b1, OP_MULT, 5'd1, 5'd2, 16'h1234);
    step();
    drive(1'b0, OP_NOP, 5'd0, 5'd0, 16'h0);
    @(negedge clk);
    check("mult_inst", out_inst, 32'h0);
    check("mult_err", 32'(out_err), 32'd1);
    check("mult_err_count", 32'(err_count), 32'd1);
    step();

    // Four more errors: wide counter at 5, narrow counter pinned at 3
    drive(1'b1, OP_J, 5'd0, 5'd0, 16'h0);
    repeat (4) step();
    drive(1'b0, OP_NOP, 5'd0, 5'd0, 16'h0);
    @(negedge clk);
    check("err_count_5", 32'(err_count), 32'd5);
    check("err_count_sat", 32'(err_count_s), 32'd3);
    step();
    step();

    // Backpressure: two accepted, third held off until one cycle after first pop
    out_ready = 1'b0;
    drive(1'b1, OP_ADDU, 5'd1, 5'd2, 16'h1234);
    step();
    drive(1'b1, OP_BNE, 5'd31, 5'd0, 16'hFFFE);
    step();
    drive(1'b1, OP_TNE, 5'd4, 5'd17, 16'h0008);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head", out_inst, 32'h2422_1234);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("full_pop_in_ready", 32'(in_ready), 32'd0);
    step();
    @(negedge clk);
    check("after_pop_head", out_inst, 32'h17E0_FFFE);
    check("after_pop_in_ready", 32'(in_ready), 32'd1);
    step();
    drive(1'b0, OP_NOP, 5'd0, 5'd0, 16'h0);
    @(negedge clk);
    check("third_head", out_inst, 32'h048E_0008);
    step();
    step();

    // Reset with two entries buffered
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 5'd1, 5'd1, 16'h0001);
    step();
    drive(1'b1, OP_DIV, 5'd2, 5'd2, 16'h0002);
    step();
    rst = 1'b1;
    drive(1'b1, OP_OR, 5'd3, 5'd3, 16'h0003);
    @(negedge clk);
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    check("rst_mid_out_valid", 32'(out_valid), 32'd1);
    step();
    rst = 1'b0;
    drive(1'b0, OP_NOP, 5'd0, 5'd0, 16'h0);
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_err_count", 32'(err_count), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Sweep every operation with random fields and random backpressure
    cur = cur.first();
    for (int i = 0; i < 240; i++) begin
      step();
      drive(($urandom_range(3) != 0), cur, 5'($urandom), 5'($urandom), 16'($urandom));
      out_ready = ($urandom_range(2) != 0);
      if (in_valid) cur = cur.next();
    end
    step();
    drive(1'b0, OP_NOP, 5'd0, 5'd0, 16'h0);
    out_ready = 1'b1;
    repeat (5) step();
    @(negedge clk);
    check("drained", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
